// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for the debounced-key consumer path.
//   key_state_e  : decoder FSM states (idle, pressed, long-held)
//   CLK_HZ       : default system clock frequency
//   LONG_MS      : default long-press threshold in milliseconds
//   REPEAT_MS    : default auto-repeat period in milliseconds
//   ms_to_cycles : converts a duration in ms to clock cycles at a given clock rate
package key_event_decoder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPress,
        StLong
    } key_state_e;

    localparam int unsigned CLK_HZ    = 50_000_000;
    localparam int unsigned LONG_MS   = 1000;
    localparam int unsigned REPEAT_MS = 200;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        longint unsigned cycles;
        // Widen before multiplying so large clock rates cannot overflow.
        cycles = (64'(clk_hz) * 64'(ms)) / 64'd1000;
        return 32'(cycles);
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Press/release edge detector for a clean, clk-synchronous key level.
//   clk       : system clock
//   rst       : synchronous reset, active-low
//   key_level : debounced key level
//   pe        : combinational, high while key_level is pressed and was released last cycle
//   re        : combinational, high while key_level is released and was pressed last cycle
// The history register resets to the released level, so a key held through reset
// shows up as a press edge in the first cycle after reset.
module key_edge_detect #(
    parameter logic PRESS_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_level,
    output logic pe,
    output logic re
);

    logic key_prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            key_prev_q <= ~PRESS_LEVEL;
        end else begin
            key_prev_q <= key_level;
        end
    end

    assign pe = (key_level == PRESS_LEVEL) && (key_prev_q != PRESS_LEVEL);
    assign re = (key_level != PRESS_LEVEL) && (key_prev_q == PRESS_LEVEL);

endmodule

// File: rtl/key_event_decoder.sv
// Decodes a debounced key level into single-cycle event flags.
//   clk          : system clock
//   rst          : synchronous reset, active-low
//   key_level    : debounced key level, synchronous to clk
//   key_pressed  : registered level, high while the decoder is in the pressed or long state
//   press_flag   : 1-cycle pulse after a press edge
//   release_flag : 1-cycle pulse after a release edge
//   short_flag   : 1-cycle pulse with release_flag when released before the long threshold
//   long_flag    : 1-cycle pulse LONG_CYCLES cycles after press_flag
//   repeat_flag  : 1-cycle pulse every REPEAT_CYCLES while long-held (if REPEAT_EN)
// All flags are registered: they appear one cycle after the edge that sampled the condition.
module key_event_decoder
    import key_event_decoder_pkg::*;
#(
    parameter logic        PRESS_LEVEL   = 1'b0,
    parameter int unsigned LONG_CYCLES   = ms_to_cycles(CLK_HZ, LONG_MS),
    parameter int unsigned REPEAT_CYCLES = ms_to_cycles(CLK_HZ, REPEAT_MS),
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_level,
    output logic key_pressed,
    output logic press_flag,
    output logic release_flag,
    output logic short_flag,
    output logic long_flag,
    output logic repeat_flag
);

    localparam int unsigned HoldW = $clog2(LONG_CYCLES);
    localparam int unsigned RepW  = $clog2(REPEAT_CYCLES);

    // hold_cnt reads 0 in the press_flag cycle and advances once per cycle, so reaching
    // LONG_CYCLES-1 places long_flag exactly LONG_CYCLES cycles after press_flag.
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);
    localparam logic [RepW-1:0]  RepLast  = RepW'(REPEAT_CYCLES - 1);

    logic pe;
    logic re;

    key_edge_detect #(
        .PRESS_LEVEL (PRESS_LEVEL)
    ) u_edge (
        .clk       (clk),
        .rst       (rst),
        .key_level (key_level),
        .pe        (pe),
        .re        (re)
    );

    key_state_e       state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RepW-1:0]  rep_cnt_q, rep_cnt_d;
    logic             pressed_q, pressed_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        short_d    = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pe) begin
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = StPress;
                end
            end
            StPress: begin
                // Release wins over the terminal count in the same cycle.
                if (re) begin
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    state_d   = StIdle;
                end else if (hold_cnt_q == HoldLast) begin
                    long_d    = 1'b1;
                    rep_cnt_d = '0;
                    state_d   = StLong;
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            StLong: begin
                if (re) begin
                    release_d = 1'b1;
                    state_d   = StIdle;
                end else if (rep_cnt_q == RepLast) begin
                    repeat_d  = REPEAT_EN;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + RepW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        pressed_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            pressed_q  <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            pressed_q  <= pressed_d;
            press_q    <= press_d;
            release_q  <= release_d;
            short_q    <= short_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
        end
    end

    assign key_pressed  = pressed_q;
    assign press_flag   = press_q;
    assign release_flag = release_q;
    assign short_flag   = short_q;
    assign long_flag    = long_q;
    assign repeat_flag  = repeat_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench: two decoders (repeat enabled / disabled) share one stimulus and
// are compared every cycle against an age-based model of the key event rules.
module tb_key_event_decoder;

    localparam int unsigned LongCycles = 10;
    localparam int unsigned RepCycles  = 4;

    logic clk = 1'b0;
    logic rst;
    logic key_level;

    logic pressed1, press1, rel1, short1, long1, rep1;
    logic pressed0, press0, rel0, short0, long0, rep0;
    logic [5:0] v1, v0;

    assign v1 = {pressed1, press1, rel1, short1, long1, rep1};
    assign v0 = {pressed0, press0, rel0, short0, long0, rep0};

    always #5 clk = ~clk;

    key_event_decoder #(
        .PRESS_LEVEL   (1'b0),
        .LONG_CYCLES   (LongCycles),
        .REPEAT_CYCLES (RepCycles),
        .REPEAT_EN     (1'b1)
    ) u_dut_rep (
        .clk          (clk),
        .rst          (rst),
        .key_level    (key_level),
        .key_pressed  (pressed1),
        .press_flag   (press1),
        .release_flag (rel1),
        .short_flag   (short1),
        .long_flag    (long1),
        .repeat_flag  (rep1)
    );

    key_event_decoder #(
        .PRESS_LEVEL   (1'b0),
        .LONG_CYCLES   (LongCycles),
        .REPEAT_CYCLES (RepCycles),
        .REPEAT_EN     (1'b0)
    ) u_dut_norep (
        .clk          (clk),
        .rst          (rst),
        .key_level    (key_level),
        .key_pressed  (pressed0),
        .press_flag   (press0),
        .release_flag (rel0),
        .short_flag   (short0),
        .long_flag    (long0),
        .repeat_flag  (rep0)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: a press in progress is described only by its age, the number of cycles since
    // its press_flag cycle. Flag timing follows from plain arithmetic on that age.
    bit         m_active = 1'b0;
    int         m_age    = 0;
    logic       m_prev   = 1'b1;
    logic [5:0] exp1, exp0;

    // Per-scenario tallies taken from the repeat-enabled DUT (and repeat count of the other).
    int sn;
    int n_press, n_rel, n_short, n_long, n_rep1, n_rep0, n_held;
    int i_press, i_long, i_rep, i_rel;

    task automatic model_step(input logic k, input logic r);
        logic f_press, f_rel, f_short, f_long, f_rep;
        f_press = 1'b0;
        f_rel   = 1'b0;
        f_short = 1'b0;
        f_long  = 1'b0;
        f_rep   = 1'b0;
        if (!r) begin
            m_active = 1'b0;
            m_age    = 0;
            m_prev   = 1'b1;
        end else begin
            if (!m_active) begin
                if (k == 1'b0 && m_prev == 1'b1) begin
                    f_press  = 1'b1;
                    m_active = 1'b1;
                    m_age    = 0;
                end
            end else begin
                m_age = m_age + 1;
                if (k == 1'b1) begin
                    f_rel    = 1'b1;
                    f_short  = (m_age <= int'(LongCycles));
                    m_active = 1'b0;
                end else if (m_age == int'(LongCycles)) begin
                    f_long = 1'b1;
                end else if (m_age > int'(LongCycles) &&
                             ((m_age - int'(LongCycles)) % int'(RepCycles)) == 0) begin
                    f_rep = 1'b1;
                end
            end
            m_prev = k;
        end
        exp1 = {m_active, f_press, f_rel, f_short, f_long, f_rep};
        exp0 = {m_active, f_press, f_rel, f_short, f_long, 1'b0};
    endtask

    // Drive one cycle of inputs, then check both DUTs against the model after the edge.
    task automatic tick(input logic k, input logic r);
        rst       = r;
        key_level = k;
        model_step(k, r);
        @(negedge clk);
        cyc = cyc + 1;
        checks = checks + 1;
        if (v1 !== exp1) begin
            errors = errors + 1;
            $display("FAIL cycle %0d rep_en1 {pressed,press,rel,short,long,rep}: got %b expected %b",
                     cyc, v1, exp1);
        end
        checks = checks + 1;
        if (v0 !== exp0) begin
            errors = errors + 1;
            $display("FAIL cycle %0d rep_en0 {pressed,press,rel,short,long,rep}: got %b expected %b",
                     cyc, v0, exp0);
        end
        n_press = n_press + int'(press1);
        n_rel   = n_rel + int'(rel1);
        n_short = n_short + int'(short1);
        n_long  = n_long + int'(long1);
        n_rep1  = n_rep1 + int'(rep1);
        n_rep0  = n_rep0 + int'(rep0);
        n_held  = n_held + int'(pressed1);
        if (press1 && i_press < 0) i_press = sn;
        if (long1 && i_long < 0) i_long = sn;
        if (rep1 && i_rep < 0) i_rep = sn;
        if (rel1 && i_rel < 0) i_rel = sn;
        sn = sn + 1;
    endtask

    task automatic ticks(input logic k, input int n);
        for (int i = 0; i < n; i++) tick(k, 1'b1);
    endtask

    task automatic clear_counts();
        sn      = 0;
        n_press = 0;
        n_rel   = 0;
        n_short = 0;
        n_long  = 0;
        n_rep1  = 0;
        n_rep0  = 0;
        n_held  = 0;
        i_press = -1;
        i_long  = -1;
        i_rep   = -1;
        i_rel   = -1;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        logic k;
        int   len;
        clear_counts();

        // Reset held with key released.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        check_int("reset_outputs_rep", int'(v1), 0);
        check_int("reset_outputs_norep", int'(v0), 0);
        clear_counts();
        ticks(1'b1, 20);
        check_int("idle_no_flags", n_press + n_rel + n_short + n_long + n_rep1 + n_held, 0);

        // Short click: 4 cycles low.
        clear_counts();
        ticks(1'b0, 4);
        ticks(1'b1, 6);
        check_int("short_press_cnt", n_press, 1);
        check_int("short_release_cnt", n_rel, 1);
        check_int("short_short_cnt", n_short, 1);
        check_int("short_long_cnt", n_long, 0);
        check_int("short_held_cycles", n_held, 4);
        check_int("short_release_latency", i_rel - i_press, 4);

        // Long press with repeats: 25 cycles low.
        clear_counts();
        ticks(1'b0, 25);
        ticks(1'b1, 4);
        check_int("long_long_cnt", n_long, 1);
        check_int("long_long_latency", i_long - i_press, 10);
        check_int("long_first_repeat", i_rep - i_long, 4);
        check_int("long_repeat_cnt_en", n_rep1, 3);
        check_int("long_repeat_cnt_dis", n_rep0, 0);
        check_int("long_release_at", i_rel, 25);
        check_int("long_short_cnt", n_short, 0);

        // Release coinciding with the long terminal count.
        clear_counts();
        ticks(1'b0, 10);
        ticks(1'b1, 3);
        check_int("bnd_press_long_cnt", n_long, 0);
        check_int("bnd_press_short_cnt", n_short, 1);
        check_int("bnd_press_release_at", i_rel, 10);

        // Release coinciding with the first repeat terminal count.
        clear_counts();
        ticks(1'b0, 14);
        ticks(1'b1, 3);
        check_int("bnd_rep_long_cnt", n_long, 1);
        check_int("bnd_rep_repeat_cnt", n_rep1, 0);
        check_int("bnd_rep_release_cnt", n_rel, 1);
        check_int("bnd_rep_short_cnt", n_short, 0);

        // Reset while long-held, key kept low through and after reset.
        clear_counts();
        ticks(1'b0, 12);
        tick(1'b0, 1'b0);
        check_int("midrst_outputs", int'(v1), 0);
        tick(1'b0, 1'b1);
        check_int("midrst_repress", int'(press1), 1);
        ticks(1'b0, 2);
        ticks(1'b1, 3);
        check_int("midrst_press_cnt", n_press, 2);
        check_int("midrst_release_cnt", n_rel, 1);

        // Key toggling every cycle.
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1);
            tick(1'b1, 1'b1);
        end
        ticks(1'b1, 2);
        check_int("toggle_press_cnt", n_press, 4);
        check_int("toggle_release_cnt", n_rel, 4);
        check_int("toggle_short_cnt", n_short, 4);
        check_int("toggle_long_cnt", n_long, 0);

        // Random run lengths with occasional reset pulses; the model checks every cycle.
        k = 1'b1;
        for (int i = 0; i < 150; i++) begin
            len = int'($urandom_range(1, 24));
            k   = ~k;
            for (int j = 0; j < len; j++) begin
                tick(k, ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
